fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the async FIFO write port among N requesters in the write (clk_a) domain.
//  Grants one requester at a time for a burst of up to MAX_BURST words, then rotates priority.
//  Never writes while fifo_full_i is high.
//  Sits directly in front of the FIFO top-level wr_en_i / wr_data_i / fifo_full_o pins.
// PARAMETERS
//  N_REQ      3   number of requesters (2..8)
//  DW         4   data width, equal to the FIFO data width
//  MAX_BURST  4   max words per grant (>=1); counter width = $clog2(MAX_BURST+1)
// PORTS
//  clk_a        in   1       write-domain clock, all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid_i  in   N_REQ   per-requester word valid
//  req_data_i   in   N_REQ*DW  packed data, requester k at [k*DW +: DW]
//  req_ready_o  out  N_REQ   per-requester accept; word k transfers when valid[k] & ready[k]
//  fifo_full_i  in   1       FIFO full flag (from fifo_full_o)
//  wr_en_o      out  1       FIFO write enable (to wr_en_i)
//  wr_data_o    out  DW      FIFO write data (to wr_data_i)
//  grant_o      out  N_REQ   one-hot current grant, 0 when idle
//  busy_o       out  1       high while in BURST
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, grant=0, rr_ptr=0, burst_cnt=0.
//   All outputs 0 immediately, including combinational ones.
//  States:
//   IDLE: if any req_valid_i, pick the first valid index at or after rr_ptr (cyclic).
//     Register grant=onehot(pick), burst_cnt=0, go BURST. No write this cycle (1-cycle arbitration latency).
//   BURST (granted index g):
//     xfer = req_valid_i[g] & ~fifo_full_i.
//     req_ready_o[g] = ~fifo_full_i; all other ready bits are 0.
//     wr_en_o = xfer; wr_data_o = req_data_i[g]. Both combinational from registered grant: zero-latency pass-through.
//     On xfer: burst_cnt++.
//     Release -> IDLE when (xfer & burst_cnt==MAX_BURST-1) or ~req_valid_i[g].
//       On release: rr_ptr=(g+1) mod N_REQ, grant=0, burst_cnt=0.
//  Full: while fifo_full_i=1, grant, burst_cnt and state are held and wr_en_o=0. A full FIFO never releases a grant.
//  Simultaneous requests: strict cyclic order from rr_ptr. A requester re-requesting after release waits behind others.
//  Throughput: with continuous valid, MAX_BURST writes then 1 idle cycle per grant.
//  wr_data_o = 0 whenever wr_en_o=0 (no X leakage to the FIFO).
//  Data order per requester is preserved. No word is written twice or dropped.
//  Reset mid-burst: the burst is abandoned and the partially accepted word count is lost. After release, requester 0 has priority.
// STRUCTURE
//  Shared package fifo_arb_pkg:
//   - state encoding (IDLE=1'b0, BURST=1'b1)
//   - default DW and MAX_BURST localparams
//   - one-hot/index conversion function
//  Sub-module rr_pick:
//   - combinational, N_REQ-wide
//   - inputs req, ptr; outputs onehot, idx, any
//   - double-width mask-and-priority-encode
//  Top: state/grant/ptr/counter registers plus output mux.
// TESTING (N_REQ=3, DW=4, MAX_BURST=4, clk_a period 4ns)
//  1 Reset: rst_n=0 with all valid=1 -> wr_en_o=0, grant_o=000, req_ready_o=000, busy_o=0.
//  2 Req1 alone, valid for data 1..6:
//    -> grant_o=010 one cycle after valid; writes 1,2,3,4; one idle cycle; regrant; writes 5,6; release on valid drop.
//  3 All valid continuously -> grant sequence 001,010,100,001; 4 writes each; 1 gap cycle between grants.
//  4 fifo_full_i=1 after 2nd word of a burst for 5 cycles:
//    -> wr_en_o=0 and ready=0 for those 5 cycles, grant held, burst_cnt=2; then exactly 2 more words.
//  5 Req0 drops valid after 1 word while req2 valid -> release, rr_ptr=1, grant_o=100 on the next arbitration.
//  6 rst_n pulsed low mid-burst of req2:
//    -> outputs 0 asynchronously; after release with all valid, grant_o=001.
//    Scoreboard: FIFO read stream equals per-requester write order throughout.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// default widths and the one-hot to index helper.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int DEF_DW        = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int MAX_REQ       = 8;

    function automatic logic [2:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping cyclically, found by masking a doubled request vector.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_masked;
    logic [N_REQ-1:0]   w_oh;
    logic               w_found;

    always_comb begin
        // Upper copy supplies the wrapped-around candidates below i_ptr.
        w_masked = {i_req, i_req} & ({(2*N_REQ){1'b1}} << i_ptr);
        w_found  = 1'b0;
        w_oh     = '0;
        for (int k = 0; k < 2*N_REQ; k++) begin
            if (w_masked[k] && !w_found) begin
                w_found           = 1'b1;
                w_oh[k % N_REQ]   = 1'b1;
            end
        end
    end

    assign o_onehot = w_oh;
    assign o_idx    = IW'(oh2idx(MAX_REQ'(w_oh)));
    assign o_any    = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters,
// granting bursts of up to MAX_BURST words with zero-latency data pass-through.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk_a,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ*DW-1:0] req_data_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic                fifo_full_i,
    output logic                wr_en_o,
    output logic [DW-1:0]       wr_data_o,
    output logic [N_REQ-1:0]    grant_o,
    output logic                busy_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IW-1:0]    r_gidx;
    logic [IW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;

    logic [N_REQ-1:0] w_pick_oh;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_burst;
    logic             w_gvalid;
    logic             w_xfer;
    logic             w_last;
    logic             w_release;
    logic [IW-1:0]    w_next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .i_req    (req_valid_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_burst    = (r_state == ST_BURST);
    assign w_gvalid   = req_valid_i[r_gidx];
    assign w_xfer     = w_burst & w_gvalid & ~fifo_full_i;
    assign w_last     = (r_cnt == CW'(MAX_BURST - 1));
    // A full FIFO freezes everything, including a grant whose requester went idle.
    assign w_release  = w_burst & ~fifo_full_i & (~w_gvalid | (w_xfer & w_last));
    assign w_next_ptr = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + IW'(1);

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_pick_any) begin
                r_state <= ST_BURST;
                r_grant <= w_pick_oh;
                r_gidx  <= w_pick_idx;
                r_cnt   <= '0;
            end
        end else if (w_release) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_ptr   <= w_next_ptr;
        end else if (w_xfer) begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign busy_o      = w_burst;
    assign grant_o     = r_grant;
    assign req_ready_o = (w_burst & ~fifo_full_i) ? r_grant : '0;
    assign wr_en_o     = w_xfer;
    assign wr_data_o   = w_xfer ? req_data_i[r_gidx*DW +: DW] : '0;

endmodule
